// File: rtl/cache_sram_controller.sv
// MEM-stage data path: 2-way set-associative write-through read cache in front of
// a 64-bit-read / 32-bit-write asynchronous SRAM, stalling the pipeline via ready.
module cache_sram_controller #(
  parameter int          SRAM_WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE        = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] MEM_Result,
  output logic        ready,
  inout  wire  [63:0] SRAM_DQ,
  output logic [16:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sram_state_e;

  localparam int CNT_W = (SRAM_WAIT_CYCLES > 2) ? $clog2(SRAM_WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT_CYCLES - 1);

  sram_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             op_write;
  logic             dq_oe;
  logic [31:0]      wdata;
  logic [31:0]      last_result;

  logic [9:0]       tag_mem  [2][64];
  logic [63:0]      data_mem [2][64];
  logic [1:0][63:0] valid;
  logic [63:0]      lru;

  logic [16:0] wa;
  logic        word_sel;
  logic [5:0]  set_idx;
  logic [9:0]  tag;
  logic        hit0, hit1, hit, hit_way, fill_way;
  logic [63:0] hit_block;
  logic [31:0] hit_word;
  logic        read_req, read_hit, sram_ready;

  assign wa       = 17'((address - ADDR_BASE) >> 2);
  assign word_sel = wa[0];
  assign set_idx  = wa[6:1];
  assign tag      = wa[16:7];

  assign hit0      = valid[0][set_idx] && (tag_mem[0][set_idx] == tag);
  assign hit1      = valid[1][set_idx] && (tag_mem[1][set_idx] == tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1;
  assign fill_way  = lru[set_idx];
  assign hit_block = data_mem[hit_way][set_idx];
  assign hit_word  = word_sel ? hit_block[63:32] : hit_block[31:0];

  // A write always wins over a simultaneous read.
  assign read_req   = MEMread && !MEMwrite;
  assign read_hit   = read_req && hit && (state != BUSY);
  assign sram_ready = (state == BUSY) && (cnt == CNT_LAST);

  assign MEM_Result = read_hit ? hit_word : last_result;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ready = 1'b1;
    if (rst) begin
      unique case (state)
        IDLE:    ready = !(MEMwrite || (read_req && !hit));
        BUSY:    ready = 1'b0;
        DONE:    ready = !(read_req && !hit);
        default: ready = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      dq_oe     <= 1'b0;
      wdata     <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (MEMwrite || (MEMread && !hit)) begin
            state     <= BUSY;
            cnt       <= '0;
            op_write  <= MEMwrite;
            dq_oe     <= MEMwrite;
            wdata     <= data;
            SRAM_ADDR <= wa;
            SRAM_WE_N <= !MEMwrite;
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            dq_oe     <= 1'b0;
            SRAM_WE_N <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= '0;
      lru         <= '0;
      last_result <= '0;
    end else begin
      if (read_hit) begin
        lru[set_idx] <= !hit_way;
        last_result  <= hit_word;
      end
      if (sram_ready) begin
        if (!op_write) begin
          valid[fill_way][set_idx] <= 1'b1;
          lru[set_idx]             <= !fill_way;
        end else if (hit) begin
          lru[set_idx] <= !hit_way;
        end
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; clearing the valid bits is enough to
  // make their contents unobservable.
  always_ff @(posedge clk) begin
    if (sram_ready && !op_write) begin
      tag_mem[fill_way][set_idx]  <= tag;
      data_mem[fill_way][set_idx] <= SRAM_DQ;
    end else if (sram_ready && op_write && hit) begin
      if (word_sel) data_mem[hit_way][set_idx][63:32] <= wdata;
      else          data_mem[hit_way][set_idx][31:0]  <= wdata;
    end
  end

  assign SRAM_DQ   = dq_oe ? {32'b0, wdata} : 64'bz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_cache_sram_controller.sv
// Bench for cache_sram_controller: behavioural SRAM, scoreboard of expected load
// data and stall lengths, one task per scenario.
module tb_cache_sram_controller;

  localparam int WAIT       = 5;
  localparam int MISS_STALL = WAIT + 1;
  localparam int MAX_WAIT   = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] address, data;
  logic [31:0] mem_result;
  logic        ready;
  wire  [63:0] sram_dq;
  logic [16:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  always #5 clk = ~clk;

  cache_sram_controller #(.SRAM_WAIT_CYCLES(WAIT), .ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .MEMread(mem_read), .MEMwrite(mem_write),
    .address(address), .data(data), .MEM_Result(mem_result), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n)
  );

  // Behavioural SRAM: 64-bit word-pair reads, 32-bit writes while WE_N is low.
  logic [31:0] mem [0:2047];
  logic [10:0] even_idx;
  assign even_idx = {sram_addr[10:1], 1'b0};
  assign sram_dq  = sram_we_n ? {mem[even_idx | 11'd1], mem[even_idx]} : 64'bz;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_0011;  mem[1]   = 32'h0000_0022;
    mem[4]   = 32'h5555_5555;  mem[5]   = 32'h6666_6666;
    mem[6]   = 32'h7777_7777;  mem[7]   = 32'h8888_8888;
    mem[128] = 32'h0000_0033;  mem[129] = 32'h3333_0001;
    mem[256] = 32'h0000_0044;  mem[257] = 32'h4444_0001;
    forever begin
      @(posedge clk);
      if (!sram_we_n) mem[sram_addr[10:0]] = sram_dq[31:0];
    end
  end

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          stall;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_data, input int exp_stall,
                           input string name);
    exp_t e;
    int   stall;
    int   we_low;
    @(posedge clk); #1;
    mem_read  = !wr;
    mem_write = wr;
    address   = addr;
    data      = wd;
    e.is_read = !wr;
    e.data    = exp_data;
    e.stall   = exp_stall;
    e.name    = name;
    exp_q.push_back(e);
    stall  = 0;
    we_low = 0;
    @(negedge clk);
    while (!ready && stall < MAX_WAIT) begin
      if (!sram_we_n) we_low++;
      stall++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (stall !== e.stall)
      $display("FAIL %s stall: got %0d cycles, expected %0d", e.name, stall, e.stall);
    else n_pass++;
    if (e.is_read) begin
      n_checks++;
      if (mem_result !== e.data)
        $display("FAIL %s data: got %h, expected %h", e.name, mem_result, e.data);
      else n_pass++;
    end else begin
      n_checks++;
      if (we_low !== WAIT)
        $display("FAIL %s we_n low: got %0d cycles, expected %0d", e.name, we_low, WAIT);
      else n_pass++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; address = 32'd1024; data = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) $display("FAIL reset ready: got %b, expected 1", ready); else n_pass++;
    n_checks++;
    if (sram_we_n !== 1'b1) $display("FAIL reset we_n: got %b, expected 1", sram_we_n); else n_pass++;
    n_checks++;
    if (sram_addr !== 17'd0) $display("FAIL reset sram_addr: got %h, expected 0", sram_addr); else n_pass++;
    n_checks++;
    if (mem_result !== 32'd0) $display("FAIL reset mem_result: got %h, expected 0", mem_result); else n_pass++;
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 32'd1024, '0, 32'h0000_0011, MISS_STALL, "miss_1024");
    do_access(1'b0, 32'd1028, '0, 32'h0000_0022, 0, "hit_1028");
    idle_cycle();
  endtask

  task automatic test_write_hit();
    do_access(1'b1, 32'd1024, 32'hDEAD_BEEF, '0, MISS_STALL, "wr_hit_1024");
    n_checks++;
    if (mem[0] !== 32'hDEAD_BEEF) $display("FAIL sram_word0: got %h, expected deadbeef", mem[0]);
    else n_pass++;
    do_access(1'b0, 32'd1024, '0, 32'hDEAD_BEEF, 0, "rd_after_wr_1024");
    idle_cycle();
  endtask

  task automatic test_eviction();
    do_access(1'b0, 32'd1536, '0, 32'h0000_0033, MISS_STALL, "miss_1536");
    do_access(1'b0, 32'd2048, '0, 32'h0000_0044, MISS_STALL, "miss_2048_evict");
    do_access(1'b0, 32'd1024, '0, 32'hDEAD_BEEF, MISS_STALL, "reread_1024_evicted");
    do_access(1'b0, 32'd2048, '0, 32'h0000_0044, 0, "reread_2048_hit");
    idle_cycle();
  endtask

  task automatic test_write_miss();
    do_access(1'b1, 32'd1040, 32'hCAFE_F00D, '0, MISS_STALL, "wr_miss_1040");
    n_checks++;
    if (mem[4] !== 32'hCAFE_F00D) $display("FAIL sram_word4: got %h, expected cafef00d", mem[4]);
    else n_pass++;
    do_access(1'b0, 32'd1040, '0, 32'hCAFE_F00D, MISS_STALL, "rd_after_wr_miss_1040");
    idle_cycle();
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; address = 32'd1048;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) $display("FAIL mid_miss ready: got %b, expected 0", ready); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL mid_reset ready: got %b, expected 1", ready); else n_pass++;
    n_checks++;
    if (sram_we_n !== 1'b1) $display("FAIL mid_reset we_n: got %b, expected 1", sram_we_n); else n_pass++;
    n_checks++;
    if (mem_result !== 32'd0) $display("FAIL mid_reset mem_result: got %h, expected 0", mem_result); else n_pass++;
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 32'd1048, '0, 32'h7777_7777, MISS_STALL, "reread_1048_after_reset");
    do_access(1'b0, 32'd1028, '0, 32'h0000_0022, MISS_STALL, "reread_1028_after_reset");
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write_hit();
    test_eviction();
    test_write_miss();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/cache_sram_controller.md
Name: cache_sram_controller

Overview:
- Memory-stage data path block for the pipelined ARM core.
- Contains a 2-way set-associative, write-through read cache (cache control) and an SRAM interface controller (SRAM control).
- Sits between the MEM stage (MEMread/MEMwrite, address, data) and an external 64-bit-read / 32-bit-write asynchronous SRAM.
- Stalls the pipeline by deasserting ready while an SRAM access is in progress.

Parameters:
- SRAM_WAIT_CYCLES, 5, clock cycles of each SRAM access (read or write); must be >=2.
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEMread  in  1  load request.
- MEMwrite  in  1  store request.
- address  in  32  byte address of the access.
- data  in  32  store data.
- MEM_Result  out  32  load data; valid when ready=1 and MEMread=1.
- ready  out  1  1 = access complete or idle; 0 = stall the pipeline.
- SRAM_DQ  inout  64  SRAM data bus; read returns {word[2k+1], word[2k]}; write drives data on [31:0].
- SRAM_ADDR  out  17  SRAM word address.
- SRAM_WE_N  out  1  active-low write enable.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied to 0.

Behaviour:
Address map:
- word address wa = (address - ADDR_BASE) >> 2, truncated to 17 bits; SRAM_ADDR = wa.
- Cache word select = wa[0]; set index = wa[6:1] (64 sets); tag = wa[16:7] (10 bits).

Cache organisation:
- Each set has 2 ways. Each way holds valid, 10-bit tag, and a 64-bit block (two words).
- Each set has one LRU bit naming the way to replace next.

Reset (rst=0, asynchronous):
- All valid bits and LRU bits cleared; SRAM control returns to IDLE with counter 0.
- Outputs: SRAM_WE_N=1, SRAM_DQ=high-Z, SRAM_ADDR=0, ready=1, MEM_Result=0.
- A reset mid-access aborts the access; no cache fill happens.

Read hit (MEMread=1, valid and tag match in either way):
- MEM_Result is combinational from the hitting way's selected word; ready=1 in the same cycle.
- The LRU bit is set to the other way at the clock edge.

Read miss:
- ready=0 immediately (combinational).
- SRAM control enters BUSY: SRAM_ADDR = wa, SRAM_WE_N=1, SRAM_DQ released.
- The counter runs SRAM_WAIT_CYCLES cycles. On the last cycle SRAM_DQ is latched into a 64-bit read register and sram_ready pulses for one cycle.
- On that edge the LRU way of the set is filled (valid=1, tag, block) and the LRU bit flips to the other way.
- The following cycle is a hit: ready=1, MEM_Result = the requested word.
- Net: ready low for SRAM_WAIT_CYCLES+1 cycles per miss.

Write (MEMwrite=1), write-through, no-write-allocate:
- ready=0; SRAM control drives SRAM_DQ={32'b0,data}, SRAM_ADDR=wa, SRAM_WE_N=0 for SRAM_WAIT_CYCLES cycles.
- On completion, if the block is present in the cache, the selected word is updated in place and LRU is updated; on a miss the cache is not changed.
- ready=1 in the cycle after completion; the request is then considered retired.
- A write miss never allocates.

Handshake:
- The requester holds MEMread/MEMwrite, address and data stable while ready=0.
- After completion, the block must not restart the same request: a one-cycle DONE state is held while the request stays asserted, then returns to IDLE.

Simultaneous MEMread and MEMwrite:
- The write takes priority; the read is ignored.

No request:
- ready=1; MEM_Result holds the last value; no SRAM activity (SRAM_WE_N=1, bus high-Z).

SRAM control states and transitions:
- IDLE -> BUSY on a read miss or write.
- BUSY -> DONE when the counter reaches SRAM_WAIT_CYCLES-1.
- DONE -> IDLE unconditionally.

Test Plan:
- Reset, then MEMread at address 1024 with SRAM word0=0x11, word1=0x22 -> ready=0 for 6 cycles, then ready=1, MEM_Result=0x11.
- Immediately after, MEMread at 1028 -> same-cycle hit, ready stays 1, MEM_Result=0x22, no SRAM access.
- MEMwrite data=0xDEADBEEF at 1024 (cached) -> ready=0 for 6 cycles, SRAM_WE_N=0 during the access, SRAM word0=0xDEADBEEF; following read of 1024 is a hit returning 0xDEADBEEF.
- Read three blocks mapping to set 0 (1024, 1024+512, 1024+1024): third fill evicts the LRU way (first block). Re-read 1024 -> miss; re-read 1024+1024 -> hit.
- MEMwrite to an uncached address 1040 -> SRAM updated; subsequent read of 1040 misses and returns the new value.
- Assert rst low during a read miss -> ready=1 and SRAM_WE_N=1 immediately; re-reading the same address after reset incurs a full miss.
